// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the instROM address, registers the returned
// instruction toward decode over valid/ready, and handles branch redirect and halt.
// Optional build macro INST_FETCH_PERF_EN adds a saturating handshake counter (inst_count_o).
module inst_fetch #(
  parameter int                 ADDR_W     = 7,
  parameter int                 DATA_W     = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [DATA_W-1:0]  HALT_OP    = 8'hFF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef INST_FETCH_PERF_EN
 ,output logic [15:0]       inst_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;

  logic handshake;
  logic halt_held;
  logic slot_open;

  // Valid/ready: a transfer happens on any edge where inst_valid_o && inst_ready_i;
  // while valid is high and ready is low, inst_o/inst_pc_o must not change.
  assign handshake = valid_q && inst_ready_i;
  assign halt_held = valid_q && (inst_q == HALT_OP);
  assign slot_open = (!valid_q || inst_ready_i) && !halt_held;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      pc_q      <= START_ADDR;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        valid_d = 1'b0;
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
        end
      end
      S_RUN: begin
        // Redirect wins over everything, including a halt waiting in the output register.
        if (branch_en_i) begin
          pc_d    = branch_target_i;
          valid_d = 1'b0;
        end else if (halt_held) begin
          if (handshake) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end
        end else if (slot_open) begin
          inst_d    = rom_data_i;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign address_o    = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
  assign busy_o       = (state_q == S_RUN);
  assign done_o       = (state_q == S_DONE);

`ifdef INST_FETCH_PERF_EN
  logic [15:0] cnt_q, cnt_d;

  // Start can only be taken outside RUN, where no handshake is possible.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != S_RUN) && start_i) begin
      cnt_d = '0;
    end else if (handshake && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign inst_count_o = cnt_q;
`endif

endmodule
